// File: rtl/stream_checker_pkg.sv
// ---------------------------------------------------------------------------
// stream_checker_pkg
// Shared constants for the stream checker:
//   - FSM state encoding (IDLE / CMP / DONE)
//   - backpressure LFSR width, seed, feedback taps and ready-bit mask
// ---------------------------------------------------------------------------
package stream_checker_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CMP  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Fibonacci form:
  // feedback = b0 ^ b2 ^ b3 ^ b5, shifted in at the MSB.
  localparam int          LFSR_W    = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  // Ready in IDLE is lfsr[0] | lfsr[3] (roughly 75% duty).
  localparam logic [15:0] LFSR_READY_MASK = 16'h0009;

endpackage

// File: rtl/chk_lfsr.sv
// ---------------------------------------------------------------------------
// chk_lfsr
// Fibonacci LFSR with enable and reset seed. Shifts right; the XOR of the
// tapped bits enters at the MSB.
// Ports:
//   clk     in   clock
//   rst     in   asynchronous active-high reset (loads SEED)
//   i_en    in   advance one step this cycle
//   o_lfsr  out  current LFSR state
// ---------------------------------------------------------------------------
module chk_lfsr
  import stream_checker_pkg::*;
#(
  parameter int          W    = LFSR_W,
  parameter logic [W-1:0] SEED = LFSR_SEED,
  parameter logic [W-1:0] TAPS = LFSR_TAPS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_lfsr
);

  logic [W-1:0] r_lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= SEED;
    end else if (i_en) begin
      r_lfsr <= {^(r_lfsr & TAPS), r_lfsr[W-1:1]};
    end
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/stream_checker.sv
// ---------------------------------------------------------------------------
// stream_checker
// Scoreboard at a DUT output stream. Each accepted DUT beat pops one word
// from an external expected-data queue (toggle-style pop), compares it one
// cycle later, and keeps saturating match/error/outstanding counters plus
// underflow, timeout and end-of-test pass status.
//
// Build option: define STREAM_CHECKER_RANDOM_BP_EN to throttle dut_ready in
// IDLE with a 16-bit LFSR (about 75% ready) to exercise DUT backpressure.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   dut_valid/ready valid/ready handshake for DUT beats, dut_data payload
//   exp_push        pulse: one word entered the expected queue this cycle
//   exp_pop         level toggle: each change pops one queue word
//   exp_data        queue word, stable the cycle after a pop toggle
//   done            end-of-stimulus level
//   match_cnt       beats compared equal
//   err_cnt         mismatches plus underflows
//   outstanding     pushed-but-unchecked expectations
//   mismatch        one-cycle pulse after a failed compare
//   underflow       sticky: beat accepted with nothing expected
//   timeout         sticky: idle too long with expectations outstanding
//   finished        high in DONE
//   pass            finished with no errors, nothing outstanding, no timeout
// ---------------------------------------------------------------------------
module stream_checker
  import stream_checker_pkg::*;
#(
  parameter int DW      = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dut_valid,
  output logic             dut_ready,
  input  logic [DW-1:0]    dut_data,
  input  logic             exp_push,
  output logic             exp_pop,
  input  logic [DW-1:0]    exp_data,
  input  logic             done,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] outstanding,
  output logic             mismatch,
  output logic             underflow,
  output logic             timeout,
  output logic             finished,
  output logic             pass
);

  localparam int               TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           r_state, w_state_next;
  logic [DW-1:0]    r_capture;
  logic             r_exp_pop, r_mismatch, r_underflow, r_timeout;
  logic [CNT_W-1:0] r_match_cnt, r_err_cnt, r_outstanding;
  logic [TMO_W-1:0] r_tmo_cnt, w_tmo_next;

  logic w_idle, w_cmp, w_fin, w_bp_ready;
  logic w_accept, w_has_exp, w_pop, w_underflow_hit, w_cmp_err;

`ifdef STREAM_CHECKER_RANDOM_BP_EN
  logic [LFSR_W-1:0] w_lfsr;

  chk_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .i_en   (1'b1),
    .o_lfsr (w_lfsr)
  );

  assign w_bp_ready = |(w_lfsr & LFSR_READY_MASK);
`else
  assign w_bp_ready = 1'b1;
`endif

  // A same-cycle push counts as available: the queue already holds the word
  // by the time the pop toggle reaches it.
  assign w_accept        = dut_valid & dut_ready;
  assign w_has_exp       = (r_outstanding != '0) | exp_push;
  assign w_pop           = w_accept & w_has_exp;
  assign w_underflow_hit = w_accept & ~w_has_exp;
  assign w_cmp_err       = w_cmp & (exp_data != r_capture);

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // FSM: next state. A beat accepted together with done is compared first.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pop)     w_state_next = ST_CMP;
        else if (done) w_state_next = ST_DONE;
      end
      ST_CMP:  w_state_next = done ? ST_DONE : ST_IDLE;
      ST_DONE: w_state_next = ST_DONE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_idle    = (r_state == ST_IDLE);
    w_cmp     = (r_state == ST_CMP);
    w_fin     = (r_state == ST_DONE);
    dut_ready = w_idle & w_bp_ready;
  end

  // Idle watchdog: only runs in IDLE while something is expected.
  always_comb begin
    w_tmo_next = r_tmo_cnt;
    if (w_accept || r_outstanding == '0) begin
      w_tmo_next = '0;
    end else if (w_idle && r_tmo_cnt != TMO_LIMIT) begin
      w_tmo_next = r_tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_capture     <= '0;
      r_exp_pop     <= 1'b0;
      r_mismatch    <= 1'b0;
      r_underflow   <= 1'b0;
      r_timeout     <= 1'b0;
      r_match_cnt   <= '0;
      r_err_cnt     <= '0;
      r_outstanding <= '0;
      r_tmo_cnt     <= '0;
    end else begin
      if (w_pop) begin
        r_capture <= dut_data;
        r_exp_pop <= ~r_exp_pop;
      end

      r_mismatch <= w_cmp_err;

      if (w_underflow_hit) r_underflow <= 1'b1;

      if (w_cmp && !w_cmp_err && r_match_cnt != CNT_MAX) begin
        r_match_cnt <= r_match_cnt + 1'b1;
      end

      // Underflow (IDLE) and compare error (CMP) are mutually exclusive.
      if ((w_underflow_hit || w_cmp_err) && r_err_cnt != CNT_MAX) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end

      if (exp_push && !w_pop) begin
        if (r_outstanding != CNT_MAX) r_outstanding <= r_outstanding + 1'b1;
      end else if (w_pop && !exp_push) begin
        if (r_outstanding != '0) r_outstanding <= r_outstanding - 1'b1;
      end

      r_tmo_cnt <= w_tmo_next;
      if (w_tmo_next == TMO_LIMIT) r_timeout <= 1'b1;
    end
  end

  assign exp_pop     = r_exp_pop;
  assign mismatch    = r_mismatch;
  assign underflow   = r_underflow;
  assign timeout     = r_timeout;
  assign match_cnt   = r_match_cnt;
  assign err_cnt     = r_err_cnt;
  assign outstanding = r_outstanding;
  assign finished    = w_fin;
  assign pass        = w_fin & (r_err_cnt == '0) & (r_outstanding == '0) & ~r_timeout;

endmodule

// File: doc/stream_checker.md
Name: stream_checker

Overview:
- Downstream consumer of the testbench expected-data queue model; acts as the scoreboard at a DUT's output stream.
- Accepts DUT output beats on a valid/ready interface and pops one expected word per beat from the queue.
- Compares the two words and keeps match/error statistics, timeout and end-of-test pass status.
- Clocked, synthesizable-style RTL so it can also sit in on-FPGA self-test benches.

Parameters:
DW, 32, data width of DUT beats and expected words
CNT_W, 16, width of match/error/outstanding counters (saturating)
TIMEOUT, 1024, idle cycles with outstanding expectations before timeout flag sets

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
dut_valid  in  1  DUT output beat valid
dut_ready  out  1  checker ready to accept beat
dut_data  in  DW  DUT output data
exp_push  in  1  one-cycle pulse: one word was pushed into the expected queue this cycle
exp_pop  out  1  toggle-style pop: every level change pops exactly one queue word
exp_data  in  DW  word returned by the queue after a pop
done  in  1  end-of-stimulus indication, level
match_cnt  out  CNT_W  beats compared equal
err_cnt  out  CNT_W  mismatches plus underflows
outstanding  out  CNT_W  pushed-but-unchecked expectations
mismatch  out  1  one-cycle pulse on a failed compare
underflow  out  1  sticky: beat accepted with outstanding==0
timeout  out  1  sticky: TIMEOUT exceeded
finished  out  1  high in DONE state
pass  out  1  valid when finished: err_cnt==0 && outstanding==0 && !timeout

Behaviour:
- Reset: all outputs 0, state IDLE, exp_pop=0, internal capture register 0. Reset is asynchronous and may assert mid-compare; any beat in flight is dropped.
- States: IDLE, CMP, DONE.
- IDLE:
  - dut_ready=1.
  - On an accepted beat (dut_valid&&dut_ready) with outstanding>0 (or exp_push this cycle): capture dut_data, toggle exp_pop, go to CMP.
  - Accepted beat with outstanding==0 and no exp_push: no pop, err_cnt+1, set underflow, stay in IDLE.
- CMP:
  - dut_ready=0.
  - exp_data is stable one cycle after the toggle; compare at the next edge against the captured data.
  - Equal: match_cnt+1. Unequal: err_cnt+1 and mismatch pulses 1 cycle.
  - Return to IDLE. Throughput is 1 beat per 2 cycles; compare latency is 1 cycle after accept.
- done asserted in IDLE: go to DONE. done in CMP: finish the compare first, then go to DONE.
- DONE: terminal until reset. dut_ready=0 and finished=1. Later exp_push pulses still increment outstanding, so pass updates.
- outstanding:
  - +1 on exp_push, -1 on pop.
  - Simultaneous push and pop: unchanged.
  - Saturates at 2^CNT_W-1 and at 0.
- match_cnt and err_cnt saturate at all-ones and never wrap.
- Timeout counter:
  - Increments each IDLE cycle with outstanding>0 and no accept.
  - Clears on accept or when outstanding==0.
  - Reaching TIMEOUT sets timeout (sticky).
- exp_pop is a registered level; it changes only on the accept edge, never twice per beat.

Optional Feature:
- Macro STREAM_CHECKER_RANDOM_BP_EN.
- When defined:
  - A 16-bit maximal LFSR (seed 16'hACE1 at reset) advances every cycle.
  - In IDLE, dut_ready = lfsr[0] | lfsr[3], giving about 75% ready.
  - Exercises DUT backpressure.
- When undefined:
  - No LFSR logic.
  - dut_ready = 1 in IDLE.
- CMP and DONE still force dut_ready=0 in both builds.

Decomposition:
- Package stream_checker_pkg:
  - state encoding (IDLE/CMP/DONE localparams);
  - LFSR width, seed and tap constants.
- One natural sub-module: chk_lfsr (Fibonacci LFSR with enable and seed), instantiated only under the macro.

Test Plan:
- 4 exp_push pulses with data 1,2,3,4 queued, then DUT beats 1,2,3,4, then done → match_cnt=4, err_cnt=0, outstanding=0, finished=1, pass=1.
- Queue A5, DUT beat 5A → mismatch pulse 1 cycle, err_cnt=1, pass=0 after done.
- DUT beat with no prior exp_push → no exp_pop toggle, underflow=1, err_cnt=1, outstanding=0.
- 2 exp_push pulses with no DUT beats for TIMEOUT=16 cycles → timeout=1 at cycle 16; pass=0 after done.
- exp_push in the same cycle as an accept with outstanding=0 → no underflow, pop issued, outstanding stays 0.
- Reset asserted during CMP → all counters 0 and state IDLE immediately; a macro build checks dut_ready follows the LFSR sequence from seed ACE1.
